mem_port2_arbiter: RTL and testbench
====================================

Name: mem_port2_arbiter

Overview:
- Shares the OTTER memory data port (port 2: RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN/DOUT2) between two requesters: CPU load/store unit (requester 0) and a DMA engine (requester 1).
- Sequences the memory's one-cycle synchronous read latency.
- Holds address, size and sign stable through the data cycle, because the memory sizes and sign-extends DOUT2 combinationally from the current ADDR2/SIZE/SIGN.
- Sits between the requesters and the Memory block; the instruction port is untouched.

Parameters:
- RR_EN, 1, 1 = round-robin between CPU and DMA; 0 = fixed priority, CPU always wins.
- ADDR_W, 32, width of request and memory addresses.

Ports:
- ARB_CLK  in  1  clock, rising edge; same clock as MEM_CLK.
- ARB_RST_N  in  1  asynchronous, active-low reset.
- CPU_REQ  in  1  CPU access request; held with its fields until CPU_GNT.
- CPU_WE  in  1  1 = store, 0 = load.
- CPU_ADDR  in  ADDR_W  byte address.
- CPU_DIN  in  32  store data.
- CPU_SIZE  in  2  0 = byte, 1 = half, 2 = word.
- CPU_SIGN  in  1  1 = unsigned, 0 = signed.
- CPU_GNT  out  1  request accepted this cycle.
- CPU_RVALID  out  1  CPU_RDATA valid this cycle.
- CPU_RDATA  out  32  load data.
- DMA_REQ, DMA_WE, DMA_ADDR, DMA_DIN, DMA_SIZE, DMA_SIGN, DMA_GNT, DMA_RVALID, DMA_RDATA: identical to the CPU_* set, for requester 1.
- MEM_RDEN2  out  1  to memory.
- MEM_WE2  out  1  to memory.
- MEM_ADDR2  out  ADDR_W  to memory.
- MEM_DIN2  out  32  to memory.
- MEM_SIZE  out  2  to memory.
- MEM_SIGN  out  1  to memory.
- MEM_DOUT2  in  32  sized read data from memory.
- BUSY  out  1  high in the RDATA state.

Behaviour:
- Reset (async, ARB_RST_N = 0):
  - state = IDLE; last_winner = DMA, so the CPU wins the first tie.
  - All GNT, RVALID, MEM_RDEN2 and MEM_WE2 = 0.
  - RDATA outputs and the captured registers = 0.
  - MEM_ADDR2/SIZE/SIGN/DIN2 = 0.
- States: IDLE, RDATA.
- IDLE, no request:
  - All memory controls are 0.
  - Address, size and sign outputs hold the captured registers.
- IDLE, one or both REQ asserted:
  - Winner selection:
    - Only one requester asserting: that requester wins.
    - Both asserting, RR_EN = 1: the requester that is not last_winner wins.
    - Both asserting, RR_EN = 0: the CPU wins.
  - In the same cycle (combinational): the winner's GNT = 1, and the winner's ADDR/DIN/SIZE/SIGN drive MEM_*.
  - On the clock edge: last_winner <= winner; the winner's ADDR/SIZE/SIGN and id are captured.
  - Write (WE = 1): MEM_WE2 = 1, MEM_RDEN2 = 0; stay in IDLE. Back-to-back writes are 1 per cycle.
  - Read (WE = 0): MEM_RDEN2 = 1, MEM_WE2 = 0; next state = RDATA.
- RDATA:
  - MEM_ADDR2/SIZE/SIGN driven from the captured registers; MEM_RDEN2 = 0, MEM_WE2 = 0.
  - Captured owner's RVALID = 1 and its RDATA = MEM_DOUT2, combinationally in this cycle.
  - No grants in this cycle; always return to IDLE.
  - Read throughput: 1 per 2 cycles. Load latency: GNT cycle + 1.
- A losing requester keeps REQ asserted and its fields stable. It is granted no later than the second arbitration opportunity when RR_EN = 1.
- RDATA of the non-owner holds its last value; its RVALID = 0.
- The MMIO window (ADDR >= 0x10000) is passed through unchanged. The memory decodes IO_WR and the IO buffer; the arbiter applies identical read sequencing.
- Reset asserted in RDATA: the read is aborted, no RVALID is produced, and the state returns to IDLE.
- The winner's WE, SIZE and SIGN are sampled only in the GNT cycle. The requester may change them after GNT.
- GNT never asserts for a requester whose REQ = 0. Only one GNT is high per cycle.

Decomposition:
- Package otter_mem_pkg:
  - typedef enum logic {IDLE, RDATA} arb_state_t;
  - typedef enum logic {REQ_CPU = 0, REQ_DMA = 1} req_id_t;
  - constants SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2, MMIO_BASE = 32'h0001_0000.
- One sub-module, rr_pick2: 2-way round-robin/fixed-priority selector (inputs: req[1:0], last_winner, RR_EN; outputs: grant[1:0], winner id).
- The FSM and muxing stay in mem_port2_arbiter.

Test Plan:
- CPU store, SIZE = 2, addr 0x100, data 0xDEADBEEF, DMA idle:
  - Required: CPU_GNT = 1 and MEM_WE2 = 1 in the same cycle.
  - A subsequent CPU word load of 0x100 returns CPU_RVALID with 0xDEADBEEF exactly 1 cycle after GNT.
- CPU signed byte load, addr 0x103, memory word 0x80FF_FF7F:
  - Required: MEM_ADDR2 = 0x103 and SIZE = 0 held through RDATA.
  - CPU_RDATA = 0xFFFFFF80. BUSY = 1 for exactly 1 cycle.
- Both REQ held continuously, reads, RR_EN = 1, after reset:
  - Required grant order CPU, DMA, CPU, DMA, one grant per 2 cycles.
  - Each RVALID is routed only to its owner.
- Both REQ held, RR_EN = 0:
  - Required: the CPU is granted every arbitration.
  - DMA_GNT stays 0 until CPU_REQ drops, then DMA is granted the next IDLE cycle.
- DMA writes on 3 consecutive cycles, CPU idle:
  - Required: DMA_GNT = 1 on all 3 cycles, MEM_WE2 = 1 on all 3 cycles, no RDATA state.
- Assert ARB_RST_N = 0 during the RDATA cycle of a DMA read:
  - Required: DMA_RVALID never pulses; all outputs are 0 immediately.
  - After release, a pending CPU_REQ is granted first.

Source files
------------

// File: rtl/mem_port2_arbiter_pkg.sv
// Shared types for the OTTER data-port arbiter.
// Package otter_mem_pkg: states, requester ids, size codes.
package otter_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    RDATA = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  typedef struct packed {
    req_id_t    id;
    logic [1:0] size;
    logic       sign;
  } cap_t;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;
  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

endpackage

// File: rtl/mem_port2_arbiter_rr_pick2.sv
// Two-way requester selector: round-robin or fixed CPU priority.
// Pure combinational; last_winner is kept by the caller.
module rr_pick2
  import otter_mem_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req,
  input  req_id_t    last_winner,
  output logic [1:0] grant,
  output req_id_t    winner
);

  always_comb begin
    winner = REQ_CPU;
    unique case (req)
      2'b10:   winner = REQ_DMA;
      2'b11: begin
        if (RR_EN && (last_winner == REQ_CPU))
          winner = REQ_DMA;
      end
      default: winner = REQ_CPU;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    if (|req)
      grant = (winner == REQ_DMA) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_port2_arbiter.sv
// Shares OTTER memory port 2 between the CPU LSU and a DMA engine.
// Address/size/sign are held through the read data cycle.
module mem_port2_arbiter
  import otter_mem_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32
) (
  input  logic              ARB_CLK,
  input  logic              ARB_RST_N,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [31:0]       CPU_DIN,
  input  logic [1:0]        CPU_SIZE,
  input  logic              CPU_SIGN,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [31:0]       CPU_RDATA,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [ADDR_W-1:0] DMA_ADDR,
  input  logic [31:0]       DMA_DIN,
  input  logic [1:0]        DMA_SIZE,
  input  logic              DMA_SIGN,
  output logic              DMA_GNT,
  output logic              DMA_RVALID,
  output logic [31:0]       DMA_RDATA,
  output logic              MEM_RDEN2,
  output logic              MEM_WE2,
  output logic [ADDR_W-1:0] MEM_ADDR2,
  output logic [31:0]       MEM_DIN2,
  output logic [1:0]        MEM_SIZE,
  output logic              MEM_SIGN,
  input  logic [31:0]       MEM_DOUT2,
  output logic              BUSY
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  req_id_t           last_q;
  req_id_t           win;
  cap_t              cap_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dma_rdata_q;
  logic [1:0]        req_v;
  logic [1:0]        gnt;
  logic              accept;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_din;
  logic [1:0]        win_size;
  logic              win_sign;
  logic              cpu_rv;
  logic              dma_rv;

  // Arbitration only in IDLE and never while reset is held.
  assign req_v = (state_q == IDLE && ARB_RST_N)
               ? {DMA_REQ, CPU_REQ} : 2'b00;

  rr_pick2 #(
    .RR_EN (RR_EN)
  ) u_pick (
    .req         (req_v),
    .last_winner (last_q),
    .grant       (gnt),
    .winner      (win)
  );

  assign accept = |gnt;

  always_comb begin
    win_we   = CPU_WE;
    win_addr = CPU_ADDR;
    win_din  = CPU_DIN;
    win_size = CPU_SIZE;
    win_sign = CPU_SIGN;
    if (win == REQ_DMA) begin
      win_we   = DMA_WE;
      win_addr = DMA_ADDR;
      win_din  = DMA_DIN;
      win_size = DMA_SIZE;
      win_sign = DMA_SIGN;
    end
  end

  always_ff @(posedge ARB_CLK or negedge ARB_RST_N) begin
    if (!ARB_RST_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !win_we)
          state_d = RDATA;
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CPU_GNT   = 1'b0;
    DMA_GNT   = 1'b0;
    cpu_rv    = 1'b0;
    dma_rv    = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_ADDR2 = cap_addr_q;
    MEM_DIN2  = 32'h0;
    MEM_SIZE  = cap_q.size;
    MEM_SIGN  = cap_q.sign;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          CPU_GNT   = gnt[0];
          DMA_GNT   = gnt[1];
          MEM_WE2   = win_we;
          MEM_RDEN2 = !win_we;
          MEM_ADDR2 = win_addr;
          MEM_DIN2  = win_din;
          MEM_SIZE  = win_size;
          MEM_SIGN  = win_sign;
        end
      end
      RDATA: begin
        cpu_rv = (cap_q.id == REQ_CPU);
        dma_rv = (cap_q.id == REQ_DMA);
      end
      default: ;
    endcase
  end

  assign CPU_RVALID = cpu_rv;
  assign DMA_RVALID = dma_rv;
  assign BUSY       = (state_q == RDATA);
  assign CPU_RDATA  = cpu_rv ? MEM_DOUT2 : cpu_rdata_q;
  assign DMA_RDATA  = dma_rv ? MEM_DOUT2 : dma_rdata_q;

  always_ff @(posedge ARB_CLK or negedge ARB_RST_N) begin
    if (!ARB_RST_N) begin
      last_q      <= REQ_DMA;
      cap_q       <= '{id: REQ_CPU, size: 2'b00, sign: 1'b0};
      cap_addr_q  <= '0;
      cpu_rdata_q <= 32'h0;
      dma_rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        last_q     <= win;
        cap_q      <= '{id: win, size: win_size, sign: win_sign};
        cap_addr_q <= win_addr;
      end
      if (cpu_rv)
        cpu_rdata_q <= MEM_DOUT2;
      if (dma_rv)
        dma_rdata_q <= MEM_DOUT2;
    end
  end

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Bench for mem_port2_arbiter with a sized synchronous memory model.
// Read data is scored through per-requester expectation queues.
module tb_mem_port2_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_sign;
  logic [31:0] cpu_addr, cpu_din;
  logic [1:0]  cpu_size;
  logic        dma_req, dma_we, dma_sign;
  logic [31:0] dma_addr, dma_din;
  logic [1:0]  dma_size;

  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_rden2, mem_we2, mem_sign, busy;
  logic [31:0] mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  mem_size;

  logic        f_cpu_gnt, f_cpu_rvalid, f_dma_gnt, f_dma_rvalid;
  logic [31:0] f_cpu_rdata, f_dma_rdata;
  logic        f_rden2, f_we2, f_sign, f_busy;
  logic [31:0] f_addr2, f_din2;
  logic [1:0]  f_size;
  logic [31:0] f_dout2;
  assign f_dout2 = 32'hA5A5_A5A5;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b1;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] exp_v;

  mem_port2_arbiter #(.RR_EN(1'b1), .ADDR_W(32)) dut (
    .ARB_CLK(clk), .ARB_RST_N(rst_n),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr),
    .CPU_DIN(cpu_din), .CPU_SIZE(cpu_size), .CPU_SIGN(cpu_sign),
    .CPU_GNT(cpu_gnt), .CPU_RVALID(cpu_rvalid), .CPU_RDATA(cpu_rdata),
    .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr),
    .DMA_DIN(dma_din), .DMA_SIZE(dma_size), .DMA_SIGN(dma_sign),
    .DMA_GNT(dma_gnt), .DMA_RVALID(dma_rvalid), .DMA_RDATA(dma_rdata),
    .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2),
    .MEM_DIN2(mem_din2), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign),
    .MEM_DOUT2(mem_dout2), .BUSY(busy)
  );

  mem_port2_arbiter #(.RR_EN(1'b0), .ADDR_W(32)) dut_fix (
    .ARB_CLK(clk), .ARB_RST_N(rst_n),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr),
    .CPU_DIN(cpu_din), .CPU_SIZE(cpu_size), .CPU_SIGN(cpu_sign),
    .CPU_GNT(f_cpu_gnt), .CPU_RVALID(f_cpu_rvalid), .CPU_RDATA(f_cpu_rdata),
    .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr),
    .DMA_DIN(dma_din), .DMA_SIZE(dma_size), .DMA_SIGN(dma_sign),
    .DMA_GNT(f_dma_gnt), .DMA_RVALID(f_dma_rvalid), .DMA_RDATA(f_dma_rdata),
    .MEM_RDEN2(f_rden2), .MEM_WE2(f_we2), .MEM_ADDR2(f_addr2),
    .MEM_DIN2(f_din2), .MEM_SIZE(f_size), .MEM_SIGN(f_sign),
    .MEM_DOUT2(f_dout2), .BUSY(f_busy)
  );

  // Memory model: synchronous word read, combinational sizing.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_word;
  logic [31:0] sh;
  logic [9:0]  widx;
  assign widx = mem_addr2[11:2];

  always @(posedge clk) begin
    if (mem_we2) begin
      case (mem_size)
        2'd0:    mem[widx][8*mem_addr2[1:0] +: 8] <= mem_din2[7:0];
        2'd1:    mem[widx][16*mem_addr2[1] +: 16] <= mem_din2[15:0];
        default: mem[widx] <= mem_din2;
      endcase
    end
    if (mem_rden2)
      rd_word <= mem[widx];
  end

  always_comb begin
    sh = rd_word >> {mem_addr2[1:0], 3'b000};
    case (mem_size)
      2'd0:    mem_dout2 = mem_sign ? {24'h0, sh[7:0]}
                                    : {{24{sh[7]}}, sh[7:0]};
      2'd1:    mem_dout2 = mem_sign ? {16'h0, sh[15:0]}
                                    : {{16{sh[15]}}, sh[15:0]};
      default: mem_dout2 = rd_word;
    endcase
  end

  // Read-data scoreboard for the round-robin instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cpu_rvalid && dma_rvalid) begin
        checks++;
        errors++;
        $display("FAIL rvalid_both: cpu=%b dma=%b required one-hot",
                 cpu_rvalid, dma_rvalid);
      end
      if (cpu_rvalid) begin
        checks++;
        if (cpu_q.size() == 0) begin
          errors++;
          $display("FAIL cpu_rvalid_unexpected: data=%h required no rvalid",
                   cpu_rdata);
        end else begin
          exp_v = cpu_q.pop_front();
          if (cpu_rdata !== exp_v) begin
            errors++;
            $display("FAIL cpu_rdata: got %h required %h", cpu_rdata, exp_v);
          end
        end
      end
      if (dma_rvalid) begin
        checks++;
        if (dma_q.size() == 0) begin
          errors++;
          $display("FAIL dma_rvalid_unexpected: data=%h required no rvalid",
                   dma_rdata);
        end else begin
          exp_v = dma_q.pop_front();
          if (dma_rdata !== exp_v) begin
            errors++;
            $display("FAIL dma_rdata: got %h required %h", dma_rdata, exp_v);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    cpu_size = 2'd2; cpu_sign = 1'b0;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_din = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b1;
    #2;
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid,
         mem_rden2, mem_we2, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid,
                mem_rden2, mem_we2, busy});
    end
    checks++;
    if (mem_addr2 !== 32'h0 || mem_din2 !== 32'h0 ||
        mem_size !== 2'd0 || mem_sign !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h din=%h size=%0d sign=%b required 0",
               mem_addr2, mem_din2, mem_size, mem_sign);
    end
    checks++;
    if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: cpu=%h dma=%h required 0",
               cpu_rdata, dma_rdata);
    end
    cpu_req = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dma_gnt, mem_rden2, mem_we2, busy} !== 5'b0 ||
        mem_addr2 !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_reset: ctrl=%b addr=%h required 0",
               {cpu_gnt, dma_gnt, mem_rden2, mem_we2, busy}, mem_addr2);
    end
    step();
  endtask

  task automatic test_store_load();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100;
    cpu_din = 32'hDEAD_BEEF; cpu_size = 2'd2; cpu_sign = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_we2 !== 1'b1 || mem_rden2 !== 1'b0 ||
        mem_addr2 !== 32'h100 || mem_din2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_grant: gnt=%b we2=%b rden2=%b addr=%h din=%h required 1 1 0 100 deadbeef",
               cpu_gnt, mem_we2, mem_rden2, mem_addr2, mem_din2);
    end
    step();
    cpu_we = 1'b0; cpu_din = 32'h0;
    cpu_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_rden2 !== 1'b1 || mem_we2 !== 1'b0) begin
      errors++;
      $display("FAIL load_grant: gnt=%b rden2=%b we2=%b required 1 1 0",
               cpu_gnt, mem_rden2, mem_we2);
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || busy !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL load_latency: rvalid=%b busy=%b gnt=%b required 1 1 0",
               cpu_rvalid, busy, cpu_gnt);
    end
    step();
  endtask

  task automatic test_dma_writes();
    dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'd2; dma_sign = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dma_addr = 32'h300 + 32'(4 * i);
      dma_din  = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if (dma_gnt !== 1'b1 || mem_we2 !== 1'b1 || busy !== 1'b0 ||
          mem_rden2 !== 1'b0 || mem_addr2 !== dma_addr) begin
        errors++;
        $display("FAIL dma_write%0d: gnt=%b we2=%b busy=%b addr=%h required 1 1 0 %h",
                 i, dma_gnt, mem_we2, busy, mem_addr2, dma_addr);
      end
      step();
    end
    dma_we = 1'b0; dma_addr = 32'h304; dma_din = 32'h0;
    dma_q.push_back(32'hA000_0001);
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || mem_rden2 !== 1'b1) begin
      errors++;
      $display("FAIL dma_readback_grant: gnt=%b rden2=%b required 1 1",
               dma_gnt, mem_rden2);
    end
    step();
    dma_req = 1'b0;
    @(negedge clk);
    step();
  endtask

  task automatic test_sized_load();
    cpu_store(32'h100, 32'h80FF_FF7F);
    cpu_store(32'h200, 32'h1111_1111);
    cpu_store(32'h204, 32'h2222_2222);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h103;
    cpu_size = 2'd0; cpu_sign = 1'b0;
    cpu_q.push_back(32'hFFFF_FF80);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_addr2 !== 32'h103 || mem_size !== 2'd0) begin
      errors++;
      $display("FAIL byte_grant: gnt=%b addr=%h size=%0d required 1 103 0",
               cpu_gnt, mem_addr2, mem_size);
    end
    step();
    cpu_req = 1'b0; cpu_addr = 32'h0; cpu_size = 2'd2; cpu_sign = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_addr2 !== 32'h103 || mem_size !== 2'd0 ||
        mem_sign !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL byte_hold: addr=%h size=%0d sign=%b busy=%b required 103 0 0 1",
               mem_addr2, mem_size, mem_sign, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_width: busy=%b required 0", busy);
    end
    step();
    cpu_req = 1'b1; cpu_addr = 32'h102; cpu_size = 2'd1; cpu_sign = 1'b1;
    cpu_q.push_back(32'h0000_80FF);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_size !== 2'd1 || mem_sign !== 1'b1) begin
      errors++;
      $display("FAIL half_grant: gnt=%b size=%0d sign=%b required 1 1 1",
               cpu_gnt, mem_size, mem_sign);
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [8];
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
    cpu_size = 2'd2; cpu_sign = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h204;
    dma_size = 2'd2; dma_sign = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (exp_seq[i] == 2'b01) cpu_q.push_back(32'h1111_1111);
      if (exp_seq[i] == 2'b10) dma_q.push_back(32'h2222_2222);
      checks++;
      if ({dma_gnt, cpu_gnt} !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_order%0d: {dma,cpu}_gnt=%b required %b",
                 i, {dma_gnt, cpu_gnt}, exp_seq[i]);
      end
      step();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rdata !== 32'h1111_1111 || dma_rdata !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rdata_hold: cpu=%h dma=%h required 11111111 22222222",
               cpu_rdata, dma_rdata);
    end
    step();
  endtask

  task automatic test_fixed_priority();
    mon_en = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_size = 2'd2;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h204; dma_size = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (f_cpu_gnt !== ((i % 2) == 0) || f_dma_gnt !== 1'b0) begin
        errors++;
        $display("FAIL fixed_prio%0d: cpu_gnt=%b dma_gnt=%b required %b 0",
                 i, f_cpu_gnt, f_dma_gnt, (i % 2) == 0);
      end
      step();
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (f_dma_gnt !== 1'b1 || f_cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fixed_dma_after_drop: dma_gnt=%b cpu_gnt=%b required 1 0",
               f_dma_gnt, f_cpu_gnt);
    end
    step();
    dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if (f_dma_rvalid !== 1'b1 || f_dma_rdata !== 32'hA5A5_A5A5 ||
        f_cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_dma_rdata: rvalid=%b data=%h cpu_rvalid=%b required 1 a5a5a5a5 0",
               f_dma_rvalid, f_dma_rdata, f_cpu_rvalid);
    end
    step();
  endtask

  task automatic test_reset_abort();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cpu_q.delete();
    dma_q.delete();
    mon_en = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h304; dma_size = 2'd2;
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_dma_grant: gnt=%b required 1", dma_gnt);
    end
    step();
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_size = 2'd2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_rden2, mem_we2,
         busy} !== 7'b0 || mem_addr2 !== 32'h0 || dma_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs: ctrl=%b addr=%h dma_rdata=%h required 0",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_rden2,
                mem_we2, busy}, mem_addr2, dma_rdata);
    end
    @(negedge clk);
    checks++;
    if (dma_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reset: dma_rvalid=%b cpu_gnt=%b required 0 0",
               dma_rvalid, cpu_gnt);
    end
    step();
    rst_n = 1'b1;
    cpu_q.push_back(32'h1111_1111);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_cpu_first: cpu_gnt=%b dma_gnt=%b required 1 0",
               cpu_gnt, dma_gnt);
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_din = 32'h0;
    cpu_size = 2'd0; cpu_sign = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_din = 32'h0;
    dma_size = 2'd0; dma_sign = 1'b0;
    test_reset();
    test_store_load();
    test_dma_writes();
    test_sized_load();
    test_round_robin();
    test_fixed_priority();
    test_reset_abort();
    checks++;
    if (cpu_q.size() != 0 || dma_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: cpu_left=%0d dma_left=%0d required 0 0",
               cpu_q.size(), dma_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
